// File: rtl/pulpino_board_io_top.sv
// DE1-SoC board top for the PULPino test image: reset/input conditioning, boot sequencer,
// periodic timer interrupt and status display on LEDR / GPIO_1.
module pulpino_board_io_top #(
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_8000,
  parameter int          SETUP_CYCLES = 350,
  parameter int          TIMER_PERIOD = 25000
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  inout  wire [35:0] GPIO_0,
  inout  wire [35:0] GPIO_1
);

  localparam int SC_W = $clog2(SETUP_CYCLES + 1);
  localparam int TM_W = $clog2(TIMER_PERIOD + 1);
  localparam logic [SC_W-1:0] SETUP_LAST = SC_W'(SETUP_CYCLES - 1);
  localparam logic [TM_W-1:0] TIMER_LAST = TM_W'(TIMER_PERIOD - 1);

  // Core straps tied off for the test image.
  localparam logic FETCH_ENABLE = 1'b1;
  localparam logic TEST_MODE    = 1'b0;
  localparam logic CLOCK_GATING = 1'b0;

  // Input bundle {GPIO_0[0], SW, KEY[3:1]}; keys idle high so they reset to 1.
  localparam logic [13:0] IN_RST = {1'b0, 10'b0, 3'b111};

  typedef enum logic [1:0] {
    ST_RESET,
    ST_SETUP,
    ST_RUN
  } state_t;

  logic [1:0]      rst_sync;
  logic            rst_n;
  logic [13:0]     in_meta;
  logic [13:0]     in_sync;
  logic [2:0]      key_prev;
  logic            gpio_prev;
  logic [2:0]      key_sync;
  logic [9:0]      sw_sync;
  logic            gpio_sync;
  logic [2:0]      key_press;
  logic            gpio_rise;
  state_t          state;
  state_t          state_nxt;
  logic [SC_W-1:0] setup_cnt;
  logic [TM_W-1:0] timer;
  logic            run;
  logic            tick;
  logic            irq_set;
  logic [6:0]      irq_inc;
  logic            irq_pending;
  logic            heartbeat;
  logic [6:0]      irq_cnt;
  logic [31:0]     pc;
  logic            unused_sig;

  // Assertion is immediate via KEY[0]; release is retimed so rst_n rises on the 2nd edge.
  always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      in_meta   <= IN_RST;
      in_sync   <= IN_RST;
      key_prev  <= 3'b111;
      gpio_prev <= 1'b0;
    end else begin
      in_meta   <= {GPIO_0[0], SW, KEY[3:1]};
      in_sync   <= in_meta;
      key_prev  <= key_sync;
      gpio_prev <= gpio_sync;
    end
  end

  assign key_sync  = in_sync[2:0];
  assign sw_sync   = in_sync[12:3];
  assign gpio_sync = in_sync[13];
  assign key_press = key_prev & ~key_sync;
  assign gpio_rise = run & gpio_sync & ~gpio_prev;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state <= ST_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_SETUP;
      ST_SETUP: if (setup_cnt == SETUP_LAST) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_RESET;
    endcase
  end

  assign run = (state == ST_RUN);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)                 setup_cnt <= '0;
    else if (state == ST_SETUP) setup_cnt <= setup_cnt + 1'b1;
    else                        setup_cnt <= '0;
  end

  assign tick = run && (timer == TIMER_LAST);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)         timer <= '0;
    else if (!run || tick) timer <= '0;
    else                timer <= timer + 1'b1;
  end

  // Program counter is loaded with the boot address until RUN, then free-runs.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)             pc <= BOOT_ADDR;
    else if (!run)          pc <= BOOT_ADDR;
    else if (FETCH_ENABLE)  pc <= pc + 32'd4;
  end

  assign irq_set = tick | gpio_rise;
  assign irq_inc = {6'b0, tick} + {6'b0, gpio_rise};

  // Set beats ack; a count clear still keeps the events of that same clock.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      irq_pending <= 1'b0;
      heartbeat   <= 1'b0;
      irq_cnt     <= 7'd0;
    end else begin
      if (irq_set)           irq_pending <= 1'b1;
      else if (key_press[0]) irq_pending <= 1'b0;
      if (tick) heartbeat <= ~heartbeat;
      if (key_press[1]) irq_cnt <= irq_inc;
      else              irq_cnt <= irq_cnt + irq_inc;
    end
  end

  assign LEDR = key_sync[2] ? {irq_cnt, heartbeat, irq_pending, run} : sw_sync;

  // GPIO_0 is input-only and left undriven; GPIO_1 status pins float outside RUN.
  assign GPIO_1 = run ? {33'bz, run, heartbeat, irq_pending} : {36{1'bz}};

  assign unused_sig = ^{GPIO_0[35:1], pc, TEST_MODE, CLOCK_GATING};

endmodule

// File: tb/tb_pulpino_board_io_top.sv
// Directed bench for pulpino_board_io_top: boot timing, timer irq, keys, GPIO edge, reset.
module tb_pulpino_board_io_top;

  localparam int P = 25000;

  logic       clk = 1'b0;
  logic [3:0] key = 4'b1111;
  logic [9:0] sw = 10'd0;
  logic [9:0] ledr;
  logic       gpio0_in = 1'b0;
  wire [35:0] gpio_0;
  wire [35:0] gpio_1;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         rel;
  int         r_edge;

  assign gpio_0[0] = gpio0_in;

  // Weak pull-ups make a floating status pin read as 1.
  pullup pu0 (gpio_1[0]);
  pullup pu1 (gpio_1[1]);
  pullup pu2 (gpio_1[2]);

  pulpino_board_io_top dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .SW       (sw),
    .LEDR     (ledr),
    .GPIO_0   (gpio_0),
    .GPIO_1   (gpio_1)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the edge at which RUN is entered, or -1 on timeout.
  task automatic wait_run(output int r);
    r = -1;
    for (int i = 0; i < 500; i++) begin
      if (ledr[0]) begin
        r = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #5 key = 4'b0000;
    #1;
    check("reset_ledr", ledr, 10'h000);
    check("reset_gpio_z", gpio_1[2:0], 3'b111);

    #94 key = 4'b1111;  // t=100, negedge
    rel = cyc;

    // 2 sync edges + 1 RESET exit + 350 SETUP clocks
    wait_cyc(rel + 352);
    check("setup_ledr", ledr, 10'h000);
    check("setup_gpio_z", gpio_1[2:0], 3'b111);
    wait_run(r_edge);
    check("setup_len", r_edge - rel, 353);
    check("run_ledr", ledr, 10'h001);
    check("run_gpio", gpio_1[2:0], 3'b100);

    wait_cyc(r_edge + P - 1);
    check("pre_tick", ledr, 10'h001);
    wait_cyc(r_edge + P);
    check("tick1_ledr", ledr, 10'h00F);
    check("tick1_gpio", gpio_1[2:0], 3'b111);

    wait_cyc(r_edge + P + 5);
    key[1] = 1'b0;
    tick_n(4);
    check("ack_ledr", ledr, 10'h00D);
    key[1] = 1'b1;

    sw = 10'h2A5;
    key[3] = 1'b0;
    tick_n(3);
    check("mirror_sw", ledr, 10'h2A5);
    key[3] = 1'b1;
    sw = 10'h000;
    tick_n(3);
    check("mirror_release", ledr, 10'h00D);

    key[2] = 1'b0;
    tick_n(4);
    check("cnt_clear", ledr, 10'h005);
    key[2] = 1'b1;
    tick_n(3);

    gpio0_in = 1'b1;
    tick_n(4);
    check("gpio_irq_ledr", ledr, 10'h00F);
    check("gpio_irq_pin", gpio_1[2:0], 3'b111);
    key[1] = 1'b0;
    tick_n(4);
    check("ack2_ledr", ledr, 10'h00D);
    key[1] = 1'b1;
    tick_n(3);

    // Ack and count-clear both land on the second tick edge.
    wait_cyc(r_edge + 2 * P - 3);
    key[1] = 1'b0;
    key[2] = 1'b0;
    tick_n(2);
    check("pre_tick2", ledr, 10'h00D);
    tick_n(1);
    check("set_wins", ledr, 10'h00B);
    check("tick2_gpio", gpio_1[2:0], 3'b101);
    key = 4'b1111;
    tick_n(3);
    check("after_collision", ledr, 10'h00B);

    @(negedge clk);
    key[0] = 1'b0;
    gpio0_in = 1'b0;
    #1;
    check("async_rst_ledr", ledr, 10'h000);
    check("async_rst_gpio_z", gpio_1[2:0], 3'b111);
    repeat (5) @(negedge clk);
    key[0] = 1'b1;
    rel = cyc;

    wait_cyc(rel + 100);
    gpio0_in = 1'b1;  // edge during SETUP must be ignored
    wait_cyc(rel + 352);
    check("setup2_ledr", ledr, 10'h000);
    check("setup2_gpio_z", gpio_1[2:0], 3'b111);
    wait_run(r_edge);
    check("setup2_len", r_edge - rel, 353);
    check("run2_ledr", ledr, 10'h001);
    tick_n(5);
    check("setup_edge_ignored", ledr, 10'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
